// File: rtl/bf_pkg.sv
// bf_pkg: shared widths, opcode constants and FSM state type for the Brainfuck core
package bf_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;
  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_SF_WAIT, S_SF_CHECK, S_SB_WAIT, S_SB_CHECK, S_HALT
  } state_e;
endpackage

// File: rtl/brainfuck_core.sv
// brainfuck_core: multi-cycle Brainfuck interpreter driving an external code ROM and cell RAM
module brainfuck_core
  import bf_pkg::*;
#(
  parameter int ADDR_W = bf_pkg::ADDR_W,
  parameter int DATA_W = bf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] code_out,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr_code,
  output logic [ADDR_W-1:0] addr_array,
  output logic [DATA_W-1:0] data_out,
  output logic              write_rq,
  output logic              probe
);
  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, dp_q;
  logic [8:0]        depth_q, depth_d;
  logic [DATA_W-1:0] dout_q, data_d;
  logic              is_exec, zero, fwd;
  // write_rq/probe must be live during EXEC itself so the RAM write lands before the next FETCH read
  always_comb begin
    is_exec    = state_q == S_EXEC;
    zero       = data_in == '0;
    fwd        = state_q == S_SF_CHECK;
    write_rq   = is_exec && (code_out == OP_INC || code_out == OP_DEC);
    probe      = is_exec && code_out == OP_OUT;
    data_d     = code_out == OP_INC ? data_in + 1'b1 : code_out == OP_DEC ? data_in - 1'b1 : data_in;
    data_out   = (write_rq || probe) ? data_d : dout_q;
    depth_d    = code_out == (fwd ? OP_LOOP : OP_END) ? depth_q + 9'd1 :
                 code_out == (fwd ? OP_END : OP_LOOP) ? depth_q - 9'd1 : depth_q;
    addr_code  = pc_q;
    addr_array = dp_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      dp_q    <= '0;
      depth_q <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          if (write_rq || probe) dout_q <= data_d;
          depth_q <= 9'd1;
          dp_q    <= code_out == OP_RIGHT ? dp_q + 1'b1 : code_out == OP_LEFT ? dp_q - 1'b1 : dp_q;
          pc_q    <= code_out == OP_HALT ? pc_q : (code_out == OP_END && !zero) ? pc_q - 1'b1 : pc_q + 1'b1;
          state_q <= code_out == OP_HALT ? S_HALT :
                     (code_out == OP_LOOP && zero) ? S_SF_WAIT :
                     (code_out == OP_END && !zero) ? S_SB_WAIT : S_FETCH;
        end
        S_SF_WAIT: state_q <= S_SF_CHECK;
        S_SB_WAIT: state_q <= S_SB_CHECK;
        S_SF_CHECK: begin
          depth_q <= depth_d;
          pc_q    <= pc_q + 1'b1;
          state_q <= depth_d == '0 ? S_FETCH : S_SF_WAIT;
        end
        S_SB_CHECK: begin
          depth_q <= depth_d;
          pc_q    <= depth_d == '0 ? pc_q + 1'b1 : pc_q - 1'b1;
          state_q <= depth_d == '0 ? S_FETCH : S_SB_WAIT;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_brainfuck_core.sv
// tb_brainfuck_core: directed programs against the core with a bench-side ROM and RAM
module tb_brainfuck_core;
  logic       clk = 0;
  logic       reset = 0;
  logic [7:0] code_out, data_in, data_out;
  logic [8:0] addr_code, addr_array;
  logic       write_rq, probe;
  logic [7:0] rom [16];
  logic [7:0] ram [512];
  logic       ram_clr = 0;
  int tests = 0, fails = 0;
  int wr_cnt = 0, pr_cnt = 0, both_cnt = 0;
  logic [7:0] pr_last = 0;

  brainfuck_core dut (
    .clk(clk), .reset(reset), .code_out(code_out), .data_in(data_in),
    .addr_code(addr_code), .addr_array(addr_array), .data_out(data_out),
    .write_rq(write_rq), .probe(probe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) code_out <= addr_code < 9'd16 ? rom[addr_code[3:0]] : 8'h00;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
    end else if (write_rq) ram[addr_array] <= data_out;
    data_in <= ram[addr_array];
  end

  always @(posedge clk) if (reset) begin
    if (write_rq) wr_cnt++;
    if (probe) begin pr_cnt++; pr_last = data_out; end
    if (write_rq && probe) both_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 16; i++) rom[i] = i < s.len() ? s[i] : 8'h00;
  endtask

  // leaves the bench in cycle 1 after reset release (FETCH at PC 0)
  task automatic start(input string s);
    load(s);
    reset = 0; ram_clr = 1;
    cyc(3);
    ram_clr = 0; reset = 1;
    wr_cnt = 0; pr_cnt = 0; both_cnt = 0; pr_last = 8'hxx;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset;
    load("+");
    reset = 0;
    cyc(2);
    tests++; if (addr_code !== 9'd0) begin fails++; $display("FAIL reset addr_code got %0h want 0", addr_code); end
    tests++; if (addr_array !== 9'd0) begin fails++; $display("FAIL reset addr_array got %0h want 0", addr_array); end
    tests++; if (write_rq !== 1'b0) begin fails++; $display("FAIL reset write_rq got %b want 0", write_rq); end
    tests++; if (probe !== 1'b0) begin fails++; $display("FAIL reset probe got %b want 0", probe); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset data_out got %0h want 0", data_out); end
  endtask

  task automatic test_inc_out;
    logic [7:0] wexp = 8'b0000_1010;
    logic [7:0] pexp = 8'b0010_0000;
    start("++.");
    for (int c = 1; c <= 8; c++) begin
      tests++; if (write_rq !== wexp[c-1]) begin fails++; $display("FAIL inc_out write_rq cycle %0d got %b want %b", c, write_rq, wexp[c-1]); end
      tests++; if (probe !== pexp[c-1]) begin fails++; $display("FAIL inc_out probe cycle %0d got %b want %b", c, probe, pexp[c-1]); end
      if (c == 6) begin
        tests++; if (data_out !== 8'h02) begin fails++; $display("FAIL inc_out probe data got %0h want 02", data_out); end
      end
      cyc();
    end
    cyc(4);
    tests++; if (addr_code !== 9'd3) begin fails++; $display("FAIL inc_out halt pc got %0h want 3", addr_code); end
    tests++; if (write_rq !== 1'b0 || probe !== 1'b0) begin fails++; $display("FAIL inc_out halt idle got %b%b want 00", write_rq, probe); end
    tests++; if (ram[0] !== 8'h02) begin fails++; $display("FAIL inc_out cell0 got %0h want 02", ram[0]); end
    tests++; if (data_out !== 8'h02) begin fails++; $display("FAIL inc_out data_out hold got %0h want 02", data_out); end
  endtask

  task automatic test_move;
    start("+>++<-.");
    cyc(30);
    tests++; if (ram[0] !== 8'h00) begin fails++; $display("FAIL move cell0 got %0h want 00", ram[0]); end
    tests++; if (ram[1] !== 8'h02) begin fails++; $display("FAIL move cell1 got %0h want 02", ram[1]); end
    tests++; if (addr_array !== 9'd0) begin fails++; $display("FAIL move dp got %0h want 0", addr_array); end
    tests++; if (pr_cnt !== 1 || pr_last !== 8'h00) begin fails++; $display("FAIL move probe cnt %0d data %0h want 1/00", pr_cnt, pr_last); end
    tests++; if (addr_code !== 9'd7) begin fails++; $display("FAIL move halt pc got %0h want 7", addr_code); end
  endtask

  task automatic test_skip_loop;
    start("[+.]");
    cyc(30);
    tests++; if (pr_cnt !== 0) begin fails++; $display("FAIL skip probe count got %0d want 0", pr_cnt); end
    tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL skip write count got %0d want 0", wr_cnt); end
    tests++; if (addr_code !== 9'd4) begin fails++; $display("FAIL skip halt pc got %0h want 4", addr_code); end
  endtask

  task automatic test_loop;
    start("++[-].");
    cyc(60);
    tests++; if (wr_cnt !== 4) begin fails++; $display("FAIL loop write count got %0d want 4", wr_cnt); end
    tests++; if (pr_cnt !== 1 || pr_last !== 8'h00) begin fails++; $display("FAIL loop probe cnt %0d data %0h want 1/00", pr_cnt, pr_last); end
    tests++; if (addr_code !== 9'd6) begin fails++; $display("FAIL loop halt pc got %0h want 6", addr_code); end
    tests++; if (ram[0] !== 8'h00) begin fails++; $display("FAIL loop cell0 got %0h want 00", ram[0]); end
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL loop write_probe overlap got %0d want 0", both_cnt); end
  endtask

  task automatic test_wrap;
    start("<-.");
    cyc(20);
    tests++; if (addr_array !== 9'h1FF) begin fails++; $display("FAIL wrap dp got %0h want 1ff", addr_array); end
    tests++; if (pr_cnt !== 1 || pr_last !== 8'hFF) begin fails++; $display("FAIL wrap probe cnt %0d data %0h want 1/ff", pr_cnt, pr_last); end
    tests++; if (ram[511] !== 8'hFF) begin fails++; $display("FAIL wrap cell511 got %0h want ff", ram[511]); end
    tests++; if (addr_code !== 9'd3) begin fails++; $display("FAIL wrap halt pc got %0h want 3", addr_code); end
  endtask

  task automatic test_reset_mid_scan;
    start("[");
    cyc(20);
    tests++; if (addr_code == 9'd0) begin fails++; $display("FAIL midscan pc advancing got %0h want nonzero", addr_code); end
    tests++; if (wr_cnt !== 0 || pr_cnt !== 0) begin fails++; $display("FAIL midscan side effects wr %0d pr %0d want 0/0", wr_cnt, pr_cnt); end
    reset = 0;
    load("+.");
    cyc(3);
    tests++; if (addr_code !== 9'd0 || addr_array !== 9'd0) begin fails++; $display("FAIL midscan reset addr got %0h/%0h want 0/0", addr_code, addr_array); end
    tests++; if (write_rq !== 1'b0 || probe !== 1'b0) begin fails++; $display("FAIL midscan reset outputs got %b%b want 00", write_rq, probe); end
    reset = 1;
    wr_cnt = 0; pr_cnt = 0;
    cyc();
    tests++; if (write_rq !== 1'b1 || data_out !== 8'h01) begin fails++; $display("FAIL midscan restart exec got wr %b data %0h want 1/01", write_rq, data_out); end
    cyc(10);
    tests++; if (pr_cnt !== 1 || pr_last !== 8'h01) begin fails++; $display("FAIL midscan restart probe cnt %0d data %0h want 1/01", pr_cnt, pr_last); end
    tests++; if (addr_code !== 9'd2) begin fails++; $display("FAIL midscan restart halt pc got %0h want 2", addr_code); end
  endtask

  initial begin
    test_reset();
    test_inc_out();
    test_move();
    test_skip_loop();
    test_loop();
    test_wrap();
    test_reset_mid_scan();
    chk("no_write_probe_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/brainfuck_core.md
Name: brainfuck_core

Overview:
- Multi-cycle Brainfuck instruction interpreter.
- Fetches 8-bit ASCII opcodes from an external code ROM.
- Reads, modifies and writes 8-bit cells in an external dual-port data RAM.
- Signals each output ('.') event on `probe`.
- Sits between the program ROM and the cell RAM; both memories are separate blocks.

Parameters:
- ADDR_W, 9, width of both the code and data address buses.
- DATA_W, 8, cell and opcode width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- code_out  in  8  opcode read from the ROM at addr_code; registered read, valid one cycle after the address.
- data_in  in  8  RAM read data at addr_array; registered read, valid one cycle after the address or a write.
- addr_code  out  9  program counter (PC).
- addr_array  out  9  data pointer (DP); used as both the RAM write and read address.
- data_out  out  8  RAM write data; also the cell value presented during a probe.
- write_rq  out  1  RAM write enable, one cycle per write.
- probe  out  1  one-cycle pulse when '.' executes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - PC=0, DP=0, depth=0, state=FETCH.
  - write_rq=0, probe=0, data_out=0.
  - Reset mid-operation aborts any scan immediately. RAM contents are not cleared by the core.
- States: FETCH, EXEC, SF_WAIT, SF_CHECK, SB_WAIT, SB_CHECK, HALT.
- FETCH: drive PC, no side effects; next EXEC. This extra cycle also covers RAM read latency after a DP change or write.
- EXEC: decode code_out using data_in.
  - '+' (0x2B): data_out=data_in+1 (mod 256), write_rq=1; PC+1; next FETCH.
  - '-' (0x2D): data_out=data_in-1 (mod 256), write_rq=1; PC+1; next FETCH.
  - '>' (0x3E): DP+1, wrapping 511->0; PC+1; next FETCH.
  - '<' (0x3C): DP-1, wrapping 0->511; PC+1; next FETCH.
  - '.' (0x2E): probe=1, data_out=data_in; PC+1; next FETCH.
  - '[' (0x5B):
    - data_in!=0: PC+1; next FETCH.
    - data_in==0: depth=1, PC+1; next SF_WAIT.
  - ']' (0x5D):
    - data_in==0: PC+1; next FETCH.
    - data_in!=0: depth=1, PC-1; next SB_WAIT.
  - 0x00: next HALT; PC frozen.
  - Any other byte, including ',' (0x2C): NOP; PC+1; next FETCH.
- SF_WAIT: next SF_CHECK.
- SF_CHECK:
  - '[' : depth+1. ']' : depth-1. Other bytes: no change.
  - New depth==0: PC+1 (instruction after the matching ']'); next FETCH.
  - Otherwise: PC+1; next SF_WAIT.
- SB_WAIT: next SB_CHECK.
- SB_CHECK:
  - ']' : depth+1. '[' : depth-1.
  - New depth==0: PC+1 (instruction after the matching '['); next FETCH.
  - Otherwise: PC-1; next SB_WAIT.
- Bracket scans ignore 0x00.
- Unmatched brackets scan forever, with PC wrapping modulo 512.
- HALT: all outputs idle; PC and DP held until reset.
- Timing:
  - Simple instructions take 2 cycles.
  - Scans take 2 cycles per skipped byte.
  - write_rq and probe are never high in the same cycle and are never high outside EXEC.
  - When write_rq==0 and probe==0, data_out holds its previous value.
- depth is 9 bits; overflow is unspecified beyond wrap.
- Memory contract:
  - RAM write occurs on the clk edge where write_rq=1.
  - A read at the same address on the next edge returns the new value.

Decomposition:
- Shared package bf_pkg:
  - Opcode constants OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OUT, OP_IN, OP_LOOP, OP_END, OP_HALT.
  - State enum.
  - ADDR_W and DATA_W.
- No sub-module required. RAM (dual-access, synchronous) and ROM (synchronous, 16-entry test program) are separate blocks instantiated by the bench.

Test Plan:
- ROM "++.\0":
  - write_rq pulses in EXEC cycles 2 and 4 after reset release.
  - probe=1 with data_out=0x02.
  - Then HALT with addr_code=3 held.
- ROM "+>++<-.\0":
  - cell0=0, cell1=2; addr_array returns to 0.
  - probe shows data_out=0x00.
- ROM "[+.]\0" with zeroed RAM:
  - Forward scan skips the body; probe never asserts.
  - Halts at addr_code=4.
- ROM "++[-]." :
  - Loop runs twice; backward scan lands PC on the instruction after '['.
  - probe shows 0x00.
- ROM "<-." :
  - addr_array wraps to 0x1FF.
  - probe shows data_out=0xFF (decrement wraps 0->255).
- Hold reset low for 3 cycles mid-scan, then release:
  - addr_code=0, addr_array=0, write_rq=0, probe=0; execution restarts from PC 0.
